midi_voice_alloc: RTL and testbench

Polyphonic voice allocator between the `midi_in` decoder and the per-voice pitch/envelope chains (`note_pitch2dds`, `adsr32`). It replaces the single `reg_rs` gate and `reg7` last-note register with VOICES independent gate/note/velocity slots. It handles note-on/note-off, retriggers a note that is already held, steals the least-recently-allocated voice when all voices are busy, and honours All Notes Off.

---
 rtl/midi_voice_alloc.sv | 135 +++++++++++++
 tb/tb_midi_voice_alloc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps decoded MIDI note messages onto
// VOICES gate/note/velocity slots with retrigger, free-slot and LRU stealing.
module midi_voice_alloc #(
    parameter int         VOICES  = 4,
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ch_message,
    input  logic [3:0]            chan,
    input  logic [6:0]            note,
    input  logic [6:0]            velocity,
    input  logic [6:0]            lsb,
    output logic [VOICES-1:0]     gate,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [7*VOICES-1:0]   voice_vel,
    output logic [VOICES-1:0]     retrig
);

    localparam int RW = $clog2(VOICES);

    localparam logic [3:0] MSG_OFF = 4'b1000;
    localparam logic [3:0] MSG_ON  = 4'b1001;
    localparam logic [3:0] MSG_CC  = 4'b1011;
    localparam logic [6:0] CC_ANO  = 7'd123;
    localparam logic [RW-1:0] OLDEST = RW'(VOICES - 1);

    logic [6:0]    note_q [VOICES];
    logic [6:0]    vel_q  [VOICES];
    logic [RW-1:0] rank_q [VOICES];
    logic [RW-1:0] rank_n [VOICES];

    logic              accepted;
    logic              is_on;
    logic              is_off;
    logic              is_ano;
    logic              hit_any;
    logic              free_any;
    logic [RW-1:0]     hit_idx;
    logic [RW-1:0]     free_idx;
    logic [RW-1:0]     old_idx;
    logic [RW-1:0]     sel_idx;
    logic [VOICES-1:0] match_mask;
    logic [VOICES-1:0] retrig_n;

    // Message qualification; a zero-velocity note-on is a note-off.
    always_comb begin
        accepted = (ch_message != 4'd0) && (OMNI || (chan == CHANNEL));
        is_on    = accepted && (ch_message == MSG_ON) && (velocity != 7'd0);
        is_off   = accepted && ((ch_message == MSG_OFF) ||
                   ((ch_message == MSG_ON) && (velocity == 7'd0)));
        is_ano   = accepted && (ch_message == MSG_CC) && (lsb == CC_ANO);
    end

    // Locate the held match, the first free slot and the oldest voice.
    always_comb begin
        hit_any    = 1'b0;
        free_any   = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        match_mask = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (gate[i] && (note_q[i] == note)) begin
                hit_any    = 1'b1;
                hit_idx    = RW'(i);
                match_mask[i] = 1'b1;
            end
            if (!gate[i]) begin
                free_any = 1'b1;
                free_idx = RW'(i);
            end
            if (rank_q[i] == OLDEST) begin
                old_idx = RW'(i);
            end
        end
    end

    // Pick the target voice and derive its retrig bit and the new LRU order.
    always_comb begin
        if (hit_any) begin
            sel_idx = hit_idx;
        end else if (free_any) begin
            sel_idx = free_idx;
        end else begin
            sel_idx = old_idx;
        end
        retrig_n = '0;
        retrig_n[sel_idx] = 1'b1;
        for (int i = 0; i < VOICES; i++) begin
            if (RW'(i) == sel_idx) begin
                rank_n[i] = '0;
            end else if (rank_q[i] < rank_q[sel_idx]) begin
                rank_n[i] = rank_q[i] + 1'b1;
            end else begin
                rank_n[i] = rank_q[i];
            end
        end
    end

    // Voice state registers; reset overrides any coincident message.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate   <= '0;
            retrig <= '0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= RW'(i);
            end
        end else begin
            retrig <= '0;
            if (is_on) begin
                gate[sel_idx]   <= 1'b1;
                note_q[sel_idx] <= note;
                vel_q[sel_idx]  <= velocity;
                retrig          <= retrig_n;
                for (int i = 0; i < VOICES; i++) begin
                    rank_q[i] <= rank_n[i];
                end
            end else if (is_off) begin
                gate <= gate & ~match_mask;
            end else if (is_ano) begin
                gate <= '0;
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_flat
        assign voice_note[7*g +: 7] = note_q[g];
        assign voice_vel[7*g +: 7]  = vel_q[g];
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: directed scenarios then random
// traffic, checked against an order-list reference model.
module tb_midi_voice_alloc;

    localparam int V = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     ch_message = '0;
    logic [3:0]     chan = '0;
    logic [6:0]     note = '0;
    logic [6:0]     velocity = '0;
    logic [6:0]     lsb = '0;
    logic [V-1:0]   gate;
    logic [7*V-1:0] voice_note;
    logic [7*V-1:0] voice_vel;
    logic [V-1:0]   retrig;

    midi_voice_alloc #(.VOICES(V), .CHANNEL(4'd2), .OMNI(1'b0)) dut (
        .clk(clk), .rst(rst), .ch_message(ch_message), .chan(chan),
        .note(note), .velocity(velocity), .lsb(lsb), .gate(gate),
        .voice_note(voice_note), .voice_vel(voice_vel), .retrig(retrig)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [V-1:0]   g;
        logic [7*V-1:0] n;
        logic [7*V-1:0] v;
        logic [V-1:0]   r;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference state: order list front = most recently allocated
    bit       mg[V];
    bit [6:0] mn[V];
    bit [6:0] mv[V];
    int       order[$];

    task automatic model(input bit r, input bit [3:0] m, input bit [3:0] c,
                         input bit [6:0] n, input bit [6:0] vv,
                         input bit [6:0] l, output exp_t e);
        int idx;
        bit [V-1:0] rt;
        rt = '0;
        if (r) begin
            order = {};
            for (int i = 0; i < V; i++) begin
                mg[i] = 0; mn[i] = 0; mv[i] = 0;
                order.push_back(i);
            end
        end else if (m != 0 && c == 4'd2) begin
            if (m == 4'b1001 && vv != 0) begin
                idx = -1;
                for (int i = 0; i < V; i++)
                    if (idx < 0 && mg[i] && mn[i] == n) idx = i;
                for (int i = 0; i < V; i++)
                    if (idx < 0 && !mg[i]) idx = i;
                if (idx < 0) idx = order[$];
                mg[idx] = 1; mn[idx] = n; mv[idx] = vv;
                rt[idx] = 1'b1;
                for (int p = 0; p < order.size(); p++)
                    if (order[p] == idx) begin
                        order.delete(p);
                        break;
                    end
                order.push_front(idx);
            end else if (m == 4'b1000 || m == 4'b1001) begin
                for (int i = 0; i < V; i++)
                    if (mg[i] && mn[i] == n) mg[i] = 0;
            end else if (m == 4'b1011 && l == 7'd123) begin
                for (int i = 0; i < V; i++) mg[i] = 0;
            end
        end
        for (int i = 0; i < V; i++) begin
            e.g[i] = mg[i];
            e.n[7*i +: 7] = mn[i];
            e.v[7*i +: 7] = mv[i];
        end
        e.r = rt;
    endtask

    task automatic step(input bit r, input bit [3:0] m, input bit [3:0] c,
                        input bit [6:0] n, input bit [6:0] vv,
                        input bit [6:0] l);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ch_message = m; chan = c;
        note = n; velocity = vv; lsb = l;
        model(r, m, c, n, vv, l, e);
        q.push_back(e);
    endtask

    task automatic on(input bit [6:0] n, input bit [6:0] vv);
        step(0, 4'b1001, 4'd2, n, vv, 0);
    endtask

    task automatic off(input bit [6:0] n);
        step(0, 4'b1000, 4'd2, n, 0, 0);
    endtask

    task automatic idle();
        step(0, 4'b0000, 4'd2, 0, 0, 0);
    endtask

    // monitor: each cycle's expectation is compared mid-way through the next
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                @(negedge clk);
                checks++;
                if (gate !== e.g) begin
                    errors++;
                    $display("FAIL gate got %b want %b t=%0t", gate, e.g, $time);
                end
                checks++;
                if (voice_note !== e.n) begin
                    errors++;
                    $display("FAIL voice_note got %h want %h t=%0t",
                             voice_note, e.n, $time);
                end
                checks++;
                if (voice_vel !== e.v) begin
                    errors++;
                    $display("FAIL voice_vel got %h want %h t=%0t",
                             voice_vel, e.v, $time);
                end
                checks++;
                if (retrig !== e.r) begin
                    errors++;
                    $display("FAIL retrig got %b want %b t=%0t", retrig, e.r, $time);
                end
            end
        end
    end

    initial begin
        bit [3:0] mt[6];
        mt = '{4'd0, 4'b1000, 4'b1001, 4'b1001, 4'b1011, 4'b1110};
        // reset then first note
        step(1, 0, 2, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        on(60, 100);
        idle();
        // fill and steal
        step(1, 0, 2, 0, 0, 0);
        on(60, 10); on(62, 20); on(64, 30); on(65, 40);
        on(67, 50); on(69, 60);
        idle();
        // retrigger and off
        step(1, 0, 2, 0, 0, 0);
        on(60, 50); idle(); on(60, 90); idle();
        off(60); idle();
        on(72, 33); step(0, 4'b1001, 4'd2, 72, 0, 0); idle();
        // free-slot reuse then steal to confirm rank of reused voice
        step(1, 0, 2, 0, 0, 0);
        on(60, 1); on(62, 2); on(64, 3); on(65, 4);
        off(62); on(70, 5); on(71, 6); on(73, 7); idle();
        // filtering
        step(0, 4'b1001, 4'd3, 80, 99, 0);
        step(0, 4'b1001, 4'd2, 80, 99, 0);
        step(0, 4'b1011, 4'd2, 0, 0, 16);
        step(0, 4'b1110, 4'd2, 64, 64, 0);
        step(0, 4'b1011, 4'd2, 0, 0, 123);
        idle();
        // back-to-back and reset with strobe
        on(60, 77); off(60); idle();
        on(61, 77);
        step(1, 4'b1001, 4'd2, 62, 55, 0);
        idle();
        // random traffic
        for (int k = 0; k < 600; k++) begin
            bit r;
            r = ($urandom_range(0, 59) == 0);
            step(r, mt[$urandom_range(0, 5)],
                 ($urandom_range(0, 4) == 0) ? 4'd3 : 4'd2,
                 7'(60 + $urandom_range(0, 6)),
                 ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                 ($urandom_range(0, 1) == 0) ? 7'd123 : 7'd16);
        end
        idle();
        repeat (4) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
